// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring divider for MIPS DIV/DIVU
// One quotient bit per cycle in CALC; results are latched on DONE entry and held until the next DONE.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              div_start,
  input  logic              div_signed,
  input  logic [DATA_W-1:0] div_opr1,
  input  logic [DATA_W-1:0] div_opr2,
  input  logic              div_cancel,
  output logic              div_busy,
  output logic              div_valid,
  output logic [DATA_W-1:0] div_quot,
  output logic [DATA_W-1:0] div_rem
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] dvd_q, dvd_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [DATA_W-1:0] raw_q, raw_d;
  logic [DATA_W-1:0] quot_q, quot_d;
  logic [DATA_W-1:0] rout_q, rout_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic              dz_q, dz_d;

  logic              s1, s2;
  logic [DATA_W-1:0] abs1, abs2;
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] rem_nxt, quo_nxt;

  // Magnitudes are plain DATA_W-bit unsigned, so the most negative value maps onto itself.
  always_comb begin
    s1      = div_signed & div_opr1[DATA_W-1];
    s2      = div_signed & div_opr2[DATA_W-1];
    abs1    = s1 ? -div_opr1 : div_opr1;
    abs2    = s2 ? -div_opr2 : div_opr2;
    trial   = {rem_q, dvd_q[DATA_W-1]} - {1'b0, dvs_q};
    rem_nxt = trial[DATA_W] ? {rem_q[DATA_W-2:0], dvd_q[DATA_W-1]} : trial[DATA_W-1:0];
    quo_nxt = {dvd_q[DATA_W-2:0], ~trial[DATA_W]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    raw_d   = raw_q;
    quot_d  = quot_q;
    rout_d  = rout_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    if (div_cancel) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_start) begin
            state_d = S_CALC;
            cnt_d   = '0;
            rem_d   = '0;
            dvd_d   = abs1;
            dvs_d   = abs2;
            raw_d   = div_opr1;
            negq_d  = s1 ^ s2;
            negr_d  = s1;
            dz_d    = (div_opr2 == '0);
          end
        end
        S_CALC: begin
          rem_d = rem_nxt;
          dvd_d = quo_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = S_DONE;
            quot_d  = dz_q ? '1    : (negq_q ? -quo_nxt : quo_nxt);
            rout_d  = dz_q ? raw_q : (negr_q ? -rem_nxt : rem_nxt);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      raw_q   <= '0;
      quot_q  <= '0;
      rout_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      raw_q   <= raw_d;
      quot_q  <= quot_d;
      rout_q  <= rout_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
    end
  end

  assign div_busy  = (state_q != S_IDLE);
  assign div_valid = (state_q == S_DONE);
  assign div_quot  = quot_q;
  assign div_rem   = rout_q;

endmodule
